// File: rtl/imem_uart_loader.sv
// Serial program loader: receives an A5/LEN/words/CHK frame over 8N1 UART and
// writes the packed 16-bit words into instruction memory while holding the CPU.
module imem_uart_loader #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_RX,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W:0] WL_ONE = 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_HDR, LEN, HI, LO, CHK} state_t;

    rx_state_t        rx_state;
    logic             rx_s1, rx_s2, rx_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             byte_valid, ferr;

    state_t           state;
    logic [7:0]       len, sum, hi_byte;
    logic [TO_W-1:0]  tcnt;
    logic             timeout;

    // UART receiver: rx_d is the previous synchronized sample, used for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            rx_s1      <= UART_RX;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        rx_state <= RX_START;
                        bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (bit_cnt == CNT_W'(HALF - 1)) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == CNT_W'(CPB - 1)) begin
                        bit_cnt <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (bit_cnt == CNT_W'(CPB - 1)) begin
                        byte_valid <= rx_s2;
                        ferr       <= !rx_s2;
                        rx_state   <= RX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // tcnt is 1 on the first idle clock after byte_valid, so the abort lands TIMEOUT_CYC clocks after it
    assign timeout = !byte_valid && (tcnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= WAIT_HDR;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            sum          <= '0;
            hi_byte      <= '0;
            tcnt         <= '0;
        end else begin
            imem_we <= 1'b0;
            if (byte_valid)
                tcnt <= TO_W'(1);
            else if (state != WAIT_HDR)
                tcnt <= tcnt + TO_W'(1);
            else
                tcnt <= '0;

            if (state != WAIT_HDR && (ferr || timeout)) begin
                load_err <= 1'b1;
                state    <= WAIT_HDR;
            end else if (byte_valid) begin
                case (state)
                    WAIT_HDR: begin
                        if (rx_byte == 8'hA5) begin
                            cpu_hold     <= 1'b1;
                            load_done    <= 1'b0;
                            load_err     <= 1'b0;
                            words_loaded <= '0;
                            sum          <= '0;
                            state        <= LEN;
                        end
                    end
                    LEN: begin
                        len   <= rx_byte;
                        sum   <= rx_byte;
                        state <= (rx_byte == 8'd0) ? CHK : HI;
                    end
                    HI: begin
                        hi_byte <= rx_byte;
                        sum     <= sum + rx_byte;
                        state   <= LO;
                    end
                    LO: begin
                        sum          <= sum + rx_byte;
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_W-1:0];
                        imem_wdata   <= {hi_byte, rx_byte};
                        words_loaded <= words_loaded + WL_ONE;
                        state <= (words_loaded + WL_ONE == (ADDR_W+1)'(len)) ? CHK : HI;
                    end
                    default: begin
                        if (rx_byte == sum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state <= WAIT_HDR;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: expected memory writes are queued as
// bytes are sent and popped by the per-cycle monitor in tick().
module tb_imem_uart_loader;
    localparam int ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              UART_RX = 1'b1;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_hold, load_done, load_err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;
    logic [23:0] exp_q[$];
    logic [15:0] frame_words[8];

    imem_uart_loader #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(ADDR_W), .TIMEOUT_CYC(500)
    ) dut (
        .CLK(CLK), .RST(RST), .UART_RX(UART_RX),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    // One clock; outputs sampled 1 time unit after the rising edge
    task automatic tick();
        logic [23:0] e;
        @(posedge CLK);
        #1;
        cyc++;
        if (imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%04h required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%04h required addr=%0h data=%04h",
                             imem_addr, imem_wdata, e[23:16], e[15:0]);
                end else begin
                    $display("write addr=%0h data=%04h ok", imem_addr, imem_wdata);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        UART_RX = 1'b0;
        last_start = cyc;
        idle(10);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            idle(10);
        end
        UART_RX = stop;
        idle(10);
        UART_RX = 1'b1;
        if (!stop) idle(20);
    endtask

    // Sends A5, n, frame_words[0..n-1], checksum (bumped by one when bad=1)
    task automatic send_frame(input int n, input logic bad);
        logic [7:0] chk;
        chk = 8'(n);
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            chk = chk + frame_words[i][15:8] + frame_words[i][7:0];
            exp_q.push_back({8'(i), frame_words[i]});
            send_byte(frame_words[i][15:8]);
            send_byte(frame_words[i][7:0]);
        end
        if (bad) chk = chk + 8'd1;
        send_byte(chk);
        idle(5);
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b addr=%0h wd=%04h hold=%b done=%b err=%b wl=%0d required all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded);
        end
        RST = 1'b0;
        idle(5);
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        send_byte(8'hA5);
        send_byte(8'h02);
        checks++;
        if ({cpu_hold, load_done} !== 2'b10) begin
            errors++;
            $display("FAIL good_hold_during got hold=%b done=%b required hold=1 done=0", cpu_hold, load_done);
        end
        exp_q.push_back({8'h00, 16'h6000});
        send_byte(8'h60); send_byte(8'h00);
        exp_q.push_back({8'h01, 16'h7001});
        send_byte(8'h70); send_byte(8'h01);
        send_byte(8'hD3);
        idle(5);
        checks++;
        if ({cpu_hold, load_done, load_err, words_loaded} !== {3'b010, 9'd2}) begin
            errors++;
            $display("FAIL good_flags got hold=%b done=%b err=%b wl=%0d required hold=0 done=1 err=0 wl=2",
                     cpu_hold, load_done, load_err, words_loaded);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL good_missing_writes got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        $display("test_good_frame done");
    endtask

    task automatic test_bad_checksum();
        exp_q.push_back({8'h00, 16'h6000});
        exp_q.push_back({8'h01, 16'h7001});
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h60); send_byte(8'h00); send_byte(8'h70); send_byte(8'h01);
        send_byte(8'hD4);
        idle(5);
        checks++;
        if ({cpu_hold, load_done, load_err, words_loaded} !== {3'b101, 9'd2}) begin
            errors++;
            $display("FAIL badchk_flags got hold=%b done=%b err=%b wl=%0d required hold=1 done=0 err=1 wl=2",
                     cpu_hold, load_done, load_err, words_loaded);
        end
        frame_words[0] = 16'h1234;
        frame_words[1] = 16'hABCD;
        frame_words[2] = 16'h0F0F;
        send_frame(3, 1'b0);
        checks++;
        if ({cpu_hold, load_done, load_err, words_loaded} !== {3'b010, 9'd3}) begin
            errors++;
            $display("FAIL recover_flags got hold=%b done=%b err=%b wl=%0d required hold=0 done=1 err=0 wl=3",
                     cpu_hold, load_done, load_err, words_loaded);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL badchk_missing_writes got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        $display("test_bad_checksum done");
    endtask

    task automatic test_framing();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12, 1'b0);
        idle(5);
        checks++;
        if ({cpu_hold, load_done, load_err, words_loaded} !== {3'b101, 9'd0}) begin
            errors++;
            $display("FAIL framing_flags got hold=%b done=%b err=%b wl=%0d required hold=1 done=0 err=1 wl=0",
                     cpu_hold, load_done, load_err, words_loaded);
        end
        $display("test_framing done");
    endtask

    task automatic test_timeout();
        int c0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h60);
        c0 = last_start;
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got err=%b required 0", load_err);
        end
        while (load_err !== 1'b1 && cyc < c0 + 2000) tick();
        // Stop sample is 98 clocks after the start edge: 2 sync + 1 edge detect + 5 half-bit + 9 bits x 10
        checks++;
        if (cyc != c0 + 98 + 500) begin
            errors++;
            $display("FAIL timeout_time got %0d clocks after stop sample required 500", cyc - c0 - 98);
        end
        checks++;
        if ({cpu_hold, load_done, load_err, words_loaded} !== {3'b101, 9'd0}) begin
            errors++;
            $display("FAIL timeout_flags got hold=%b done=%b err=%b wl=%0d required hold=1 done=0 err=1 wl=0",
                     cpu_hold, load_done, load_err, words_loaded);
        end
        $display("test_timeout done");
    endtask

    task automatic test_noise();
        send_byte(8'h00);
        send_byte(8'h55);
        UART_RX = 1'b0;
        idle(3);
        UART_RX = 1'b1;
        idle(30);
        checks++;
        if ({cpu_hold, load_done, load_err} !== 3'b101) begin
            errors++;
            $display("FAIL noise_ignored got hold=%b done=%b err=%b required hold=1 done=0 err=1",
                     cpu_hold, load_done, load_err);
        end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        idle(5);
        checks++;
        if ({cpu_hold, load_done, load_err, words_loaded} !== {3'b010, 9'd0}) begin
            errors++;
            $display("FAIL empty_frame got hold=%b done=%b err=%b wl=%0d required hold=0 done=1 err=0 wl=0",
                     cpu_hold, load_done, load_err, words_loaded);
        end
        $display("test_noise done");
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'hA5); send_byte(8'h02);
        exp_q.push_back({8'h00, 16'h6000});
        send_byte(8'h60); send_byte(8'h00);
        idle(2);
        checks++;
        if (words_loaded !== 9'd1) begin
            errors++;
            $display("FAIL midload_count got wl=%0d required 1", words_loaded);
        end
        UART_RX = 1'b0;
        idle(40);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded} !== '0) begin
            errors++;
            $display("FAIL async_reset got we=%b addr=%0h wd=%04h hold=%b done=%b err=%b wl=%0d required all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded);
        end
        UART_RX = 1'b1;
        idle(5);
        RST = 1'b0;
        idle(30);
        frame_words[0] = 16'hBEEF;
        send_frame(1, 1'b0);
        checks++;
        if ({cpu_hold, load_done, load_err, words_loaded} !== {3'b010, 9'd1}) begin
            errors++;
            $display("FAIL after_reset_frame got hold=%b done=%b err=%b wl=%0d required hold=0 done=1 err=0 wl=1",
                     cpu_hold, load_done, load_err, words_loaded);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midload_missing_writes got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        $display("test_reset_mid_load done");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_framing();
        test_timeout();
        test_noise();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
